// File: rtl/spi_txn_scheduler.sv
// spi_txn_scheduler
//
// Queues single-byte SPI commands and runs them one at a time against an
// SPI top that exposes start / slaveselect / master_data and reports
// completion through spi_done (high while every chip select is idle).
// Each command produces exactly one response, in command order.
//
// Ports
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake (cmd_ready = FIFO not full)
//   cmd_ss, cmd_data            target slave (3 = invalid) and byte to send
//   rsp_valid/rsp_ready         response handshake
//   rsp_ss, rsp_data, rsp_err   slave, received byte, invalid-slave/timeout flag
//   spi_start                   one-cycle launch pulse to the SPI top
//   spi_slaveselect             slave index held for the whole transfer
//   spi_master_data             byte held for the whole transfer
//   spi_done, spi_master_rx     SPI top idle indication and received byte
//   busy                        transaction engine not idle
//   fifo_count                  command FIFO occupancy

module spi_txn_scheduler #(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic [1:0]                      cmd_ss,
   input  logic [7:0]                      cmd_data,
   output logic                            rsp_valid,
   input  logic                            rsp_ready,
   output logic [1:0]                      rsp_ss,
   output logic [7:0]                      rsp_data,
   output logic                            rsp_err,
   output logic                            spi_start,
   output logic [1:0]                      spi_slaveselect,
   output logic [7:0]                      spi_master_data,
   input  logic                            spi_done,
   input  logic [7:0]                      spi_master_rx,
   output logic                            busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [CntW-1:0] FifoFull    = CntW'(FIFO_DEPTH);
   localparam logic [TmoW-1:0] TimeoutLast = TmoW'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]      SsInvalid   = 2'd3;

   typedef enum logic [2:0] {
      StIdle,
      StLaunch,
      StWaitBusy,
      StWaitDone,
      StResp
   } state_e;

   // ------------------------------------------------------------------
   // Command FIFO
   // ------------------------------------------------------------------
   logic [1:0]      ss_mem   [FIFO_DEPTH];
   logic [7:0]      data_mem [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q;
   logic [PtrW-1:0] rd_ptr_q;
   logic [CntW-1:0] count_q;

   state_e          state_q;
   logic [TmoW-1:0] tmo_cnt_q;

   logic            push;
   logic            pop;
   logic [1:0]      head_ss;
   logic [7:0]      head_data;

   assign cmd_ready  = (count_q != FifoFull);
   assign push       = cmd_valid & cmd_ready;
   // The head is only taken when the engine is idle and the SPI top is idle too.
   assign pop        = (state_q == StIdle) && (count_q != '0) && spi_done;
   assign head_ss    = ss_mem[rd_ptr_q];
   assign head_data  = data_mem[rd_ptr_q];
   assign fifo_count = count_q;
   assign busy       = (state_q != StIdle);

   // Storage needs no reset: occupancy alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         ss_mem[wr_ptr_q]   <= cmd_ss;
         data_mem[wr_ptr_q] <= cmd_data;
      end
   end

   // Depth is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Transaction engine: state plus every registered output
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= StIdle;
         tmo_cnt_q       <= '0;
         spi_start       <= 1'b0;
         spi_slaveselect <= 2'd0;
         spi_master_data <= 8'h00;
         rsp_valid       <= 1'b0;
         rsp_ss          <= 2'd0;
         rsp_data        <= 8'h00;
         rsp_err         <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (pop) begin
                  if (head_ss == SsInvalid) begin
                     // Never reaches the SPI top; answered with an error directly.
                     rsp_valid <= 1'b1;
                     rsp_ss    <= head_ss;
                     rsp_data  <= 8'h00;
                     rsp_err   <= 1'b1;
                     state_q   <= StResp;
                  end else begin
                     // The SPI-side outputs double as the latched command.
                     spi_slaveselect <= head_ss;
                     spi_master_data <= head_data;
                     spi_start       <= 1'b1;
                     state_q         <= StLaunch;
                  end
               end
            end

            StLaunch: begin
               spi_start <= 1'b0;
               tmo_cnt_q <= '0;
               state_q   <= StWaitBusy;
            end

            // Waiting for the SPI top to leave idle.
            StWaitBusy: begin
               if (!spi_done) begin
                  tmo_cnt_q <= '0;
                  state_q   <= StWaitDone;
               end else if (tmo_cnt_q == TimeoutLast) begin
                  rsp_valid <= 1'b1;
                  rsp_ss    <= spi_slaveselect;
                  rsp_data  <= 8'h00;
                  rsp_err   <= 1'b1;
                  state_q   <= StResp;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
               end
            end

            // Waiting for the SPI top to return to idle; rx is valid on that edge.
            StWaitDone: begin
               if (spi_done) begin
                  rsp_valid <= 1'b1;
                  rsp_ss    <= spi_slaveselect;
                  rsp_data  <= spi_master_rx;
                  rsp_err   <= 1'b0;
                  state_q   <= StResp;
               end else if (tmo_cnt_q == TimeoutLast) begin
                  rsp_valid <= 1'b1;
                  rsp_ss    <= spi_slaveselect;
                  rsp_data  <= 8'h00;
                  rsp_err   <= 1'b1;
                  state_q   <= StResp;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
               end
            end

            // Response fields stay frozen until accepted.
            StResp: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state_q   <= StIdle;
               end
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: doc/spi_txn_scheduler.md
SPI_TXN_SCHEDULER -- requirements
Module: spi_txn_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: command FIFO entries (power of two, at least 2).
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: maximum cycles spent in WAIT_BUSY or in WAIT_DONE before the transaction is aborted.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cmd_valid  in  1  command offered; cmd_ready  out  1  command FIFO can accept.
REQ-007 cmd_ss  in  2  target slave (0..2; 3 invalid); cmd_data  in  8  byte to transmit.
REQ-008 rsp_valid  out  1  response available; rsp_ready  in  1  consumer accepts.
REQ-009 rsp_ss  out  2  slave of the completed command; rsp_data  out  8  byte received; rsp_err  out  1  invalid slave or timeout.
REQ-010 spi_start  out  1; spi_slaveselect  out  2; spi_master_data  out  8  drive the SPI top start, slaveselect and master_data inputs.
REQ-011 spi_done  in  1  high when all chip selects are idle; spi_master_rx  in  8  master receive byte.
REQ-012 busy  out  1  state not IDLE; fifo_count  out  clog2(FIFO_DEPTH+1)  FIFO occupancy.

Function
REQ-013 cmd_ready SHALL equal (fifo_count != FIFO_DEPTH); a push occurs on a cycle with cmd_valid & cmd_ready.
REQ-014 The FIFO SHALL be first-in first-out with wrap-around pointers; a push and a pop in the same cycle SHALL leave fifo_count unchanged.
REQ-015 Only one transaction SHALL be outstanding; responses SHALL return in command order.
REQ-016 FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESP.
REQ-017 IDLE: if the FIFO is non-empty and spi_done=1, the block SHALL pop the head and latch ss/data; if ss=3, go to RESP with rsp_err=1 and rsp_data=0x00; otherwise go to LAUNCH.
REQ-018 IDLE with spi_done=0 SHALL not pop and SHALL wait.
REQ-019 LAUNCH: spi_start=1 for exactly this one cycle, then WAIT_BUSY.
REQ-020 spi_slaveselect and spi_master_data SHALL hold the latched values from LAUNCH through WAIT_DONE and SHALL not change outside IDLE.
REQ-021 WAIT_BUSY: on spi_done=0, go to WAIT_DONE.
REQ-022 WAIT_DONE: on spi_done=1, capture spi_master_rx into rsp_data on the same edge, set rsp_err=0, and go to RESP.
REQ-023 A cycle counter SHALL clear on entry to WAIT_BUSY and to WAIT_DONE; when it reaches TIMEOUT_CYCLES-1 without the awaited edge, go to RESP with rsp_err=1 and rsp_data=0x00.
REQ-024 RESP: rsp_valid=1 with rsp_ss/rsp_data/rsp_err held stable until rsp_ready=1; the cycle after the handshake, return to IDLE.
REQ-025 Latency: for a command pushed in cycle N with the FIFO empty and spi_done=1, the pop SHALL occur in cycle N+1 and spi_start SHALL be asserted in cycle N+2.
REQ-026 Commands SHALL continue to be accepted in every state while cmd_ready=1.

Reset
REQ-027 While reset=1 at a clock edge: state IDLE, FIFO empty, fifo_count=0, counter=0.
REQ-028 After that edge: cmd_ready=1, rsp_valid=0, rsp_ss=0, rsp_data=0x00, rsp_err=0, spi_start=0, spi_slaveselect=0, spi_master_data=0x00, busy=0.
REQ-029 Reset mid-transaction SHALL discard the in-flight command and all queued commands without emitting a response.

Verification
REQ-030 Single command: push ss=1, data=0xA5 with the slave returning 0x3C -> spi_start pulses once at N+2 with spi_slaveselect=1; then a response with ss=1, data=0x3C, err=0.
REQ-031 Back-to-back: push 5 commands with FIFO_DEPTH=4 and no pops -> cmd_ready falls after 4 pushes (or 5 if one was popped); all responses return in order.
REQ-032 Invalid slave: push ss=3 -> no spi_start pulse; the response has err=1, data=0x00.
REQ-033 Timeout: hold spi_done=1 after spi_start -> after TIMEOUT_CYCLES cycles in WAIT_BUSY, the response has err=1; the next command is then launched normally.
REQ-034 Response backpressure: hold rsp_ready=0 for 10 cycles -> rsp_valid and the response fields stay stable, no new spi_start occurs, and commands still enqueue.
REQ-035 Reset during WAIT_DONE with 2 commands queued -> all outputs take their reset values and no response is emitted for the dropped commands.
